// File: rtl/scan_pattern_ctrl_pkg.sv
// Shared definitions for the scan pattern controller: FSM states, default
// geometry and the result counter width.
package wrapsim_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_L = 4;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_t;

endpackage

// File: rtl/scan_pattern_ctrl_compare.sv
// Masked chain response compare with a sticky fail flag and a saturating
// count of mismatching beats.
module scan_compare
    import wrapsim_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [N-1:0]     chain_out,
    input  logic [N-1:0]     exp_data,
    input  logic [N-1:0]     mask,
    output logic             fail,
    output logic [CNT_W-1:0] fail_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic mismatch;

    assign mismatch = |((chain_out ^ exp_data) & mask);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fail     <= 1'b0;
            fail_cnt <= '0;
        end else if (clear) begin
            fail     <= 1'b0;
            fail_cnt <= '0;
        end else if (enable && mismatch) begin
            fail     <= 1'b1;
            fail_cnt <= sat_inc(fail_cnt);
        end
    end

endmodule

// File: rtl/scan_pattern_ctrl.sv
// Streams scan patterns into N parallel chains of length L, pulses capture
// between loads, flushes the final response and scores masked mismatches.
module scan_pattern_ctrl
    import wrapsim_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int L = DEF_L
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [N-1:0]     pat_si,
    input  logic [N-1:0]     pat_exp,
    input  logic [N-1:0]     pat_mask,
    input  logic             pat_last,
    output logic             chain_en,
    output logic [N-1:0]     chain_in,
    input  logic [N-1:0]     chain_out,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic             err_underrun,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] pat_cnt
);

    localparam int SW = (L > 1) ? $clog2(L) : 1;
    localparam logic [SW-1:0] SH_LAST = SW'(L - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t        state, state_n;
    logic [SW-1:0] sh_cnt;
    logic          last_flag;
    logic          accept;
    logic          clear;
    logic          underrun;

    always_comb begin
        state_n   = state;
        pat_ready = 1'b0;
        chain_en  = 1'b0;
        chain_in  = '0;
        accept    = 1'b0;
        clear     = 1'b0;
        underrun  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_SHIFT;
                    clear   = 1'b1;
                end
            end
            S_SHIFT, S_FLUSH: begin
                pat_ready = 1'b1;
                chain_en  = pat_valid;
                chain_in  = (state == S_SHIFT) ? pat_si : '0;
                if (!pat_valid) begin
                    state_n  = S_DONE;
                    underrun = 1'b1;
                end else begin
                    accept = 1'b1;
                    if (sh_cnt == SH_LAST)
                        state_n = (state == S_SHIFT) ? S_CAPTURE : S_DONE;
                end
            end
            S_CAPTURE: state_n = last_flag ? S_FLUSH : S_SHIFT;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            sh_cnt       <= '0;
            last_flag    <= 1'b0;
            err_underrun <= 1'b0;
            pat_cnt      <= '0;
        end else begin
            state <= state_n;
            if (clear) begin
                sh_cnt       <= '0;
                last_flag    <= 1'b0;
                err_underrun <= 1'b0;
                pat_cnt      <= '0;
            end
            if (underrun)
                err_underrun <= 1'b1;
            if (accept) begin
                sh_cnt <= (sh_cnt == SH_LAST) ? '0 : sh_cnt + SW'(1);
                // Only the closing beat of a load may mark it as the final one.
                if (state == S_SHIFT && sh_cnt == SH_LAST && pat_last)
                    last_flag <= 1'b1;
            end
            if (state == S_CAPTURE)
                pat_cnt <= sat_inc(pat_cnt);
        end
    end

    scan_compare #(.N(N)) u_cmp (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .enable    (accept),
        .chain_out (chain_out),
        .exp_data  (pat_exp),
        .mask      (pat_mask),
        .fail      (fail),
        .fail_cnt  (fail_cnt)
    );

endmodule

// File: tb/tb_scan_pattern_ctrl.sv
// Directed bench for scan_pattern_ctrl (N=4, L=4) with a behavioural model
// of four 4-deep scan chains that hold their contents during capture.
module tb_scan_pattern_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        pat_valid;
    logic        pat_ready;
    logic [3:0]  pat_si;
    logic [3:0]  pat_exp;
    logic [3:0]  pat_mask;
    logic        pat_last;
    logic        chain_en;
    logic [3:0]  chain_in;
    logic [3:0]  chain_out;
    logic        busy;
    logic        done;
    logic        fail;
    logic        err_underrun;
    logic [15:0] fail_cnt;
    logic [15:0] pat_cnt;

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;
    int done_seen;

    logic [3:0] si0 [4] = '{4'h3, 4'hA, 4'h5, 4'hC};
    logic [3:0] si1 [4] = '{4'h9, 4'h6, 4'hF, 4'h1};
    logic [3:0] chain [4];

    scan_pattern_ctrl #(.N(4), .L(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pat_valid    (pat_valid),
        .pat_ready    (pat_ready),
        .pat_si       (pat_si),
        .pat_exp      (pat_exp),
        .pat_mask     (pat_mask),
        .pat_last     (pat_last),
        .chain_en     (chain_en),
        .chain_in     (chain_in),
        .chain_out    (chain_out),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .err_underrun (err_underrun),
        .fail_cnt     (fail_cnt),
        .pat_cnt      (pat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (chain_en) chain[i] <= {chain[i][2:0], chain_in[i]};
    end

    always_comb begin
        for (int i = 0; i < 4; i++) chain_out[i] = chain[i][3];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done) done_seen++;
    endtask

    // Inputs for cycle c after the start edge: c=1..4 load 0, 5 capture,
    // 6..9 load 1 (checks load 0), 10 capture, 11..14 flush (checks load 1).
    task automatic drive(input int c, input logic [3:0] flip, input logic [3:0] fmask,
                         input bit early_last);
        int k;
        pat_valid = 1'b1;
        pat_si    = 4'h0;
        pat_exp   = 4'h0;
        pat_mask  = 4'h0;
        pat_last  = 1'b0;
        if (c >= 1 && c <= 4) begin
            k        = c - 1;
            pat_si   = si0[k];
            pat_last = early_last && (k == 1);
        end else if (c >= 6 && c <= 9) begin
            k        = c - 6;
            pat_si   = si1[k];
            pat_exp  = si0[k];
            pat_mask = 4'hF;
            pat_last = (k == 3);
        end else if (c >= 11) begin
            k        = c - 11;
            pat_si   = 4'hF;
            pat_exp  = si1[k] ^ {3'b000, flip[k]};
            pat_mask = flip[k] ? fmask : 4'hF;
        end
    endtask

    // Runs one two-pattern session; drop_c/rst_c abort it at that cycle.
    task automatic session(input logic [3:0] flip, input logic [3:0] fmask, input bit hold,
                           input int drop_c, input int rst_c, input bit preload);
        done_seen = 0;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            drive(c, flip, fmask, hold);
            if (preload && c == 1) begin
                force dut.u_cmp.fail_cnt = 16'hFFFE;
                #1 release dut.u_cmp.fail_cnt;
            end
            if (c == drop_c) begin
                pat_valid = 1'b0;
                #1;
                chk("underrun_chain_en", chain_en, 0);
                tick();
                chk("underrun_done", done, 1);
                chk("underrun_flag", err_underrun, 1);
                chk("underrun_pat_cnt", pat_cnt, 0);
                pat_valid = 1'b1;
                tick();
                chk("underrun_idle", busy, 0);
                return;
            end
            if (c == rst_c) begin
                #2 reset = 1'b0;
                #1;
                chk("async_busy", busy, 0);
                chk("async_ready", pat_ready, 0);
                chk("async_chain_en", chain_en, 0);
                chk("async_pat_cnt", pat_cnt, 0);
                chk("async_fail_cnt", fail_cnt, 0);
                #1 reset = 1'b1;
                return;
            end
            #1;
            if (c == 1) begin
                chk("shift_ready", pat_ready, 1);
                chk("shift_chain_in", chain_in, 4'h3);
                chk("shift_chain_en", chain_en, 1);
            end
            if (c == 5) chk("capture_chain_en", {chain_en, pat_ready}, 2'b00);
            if (c == 6 && preload) chk("preload_value", fail_cnt, 16'hFFFE);
            if (c == 11) chk("flush_chain_in", {chain_en, chain_in}, 5'h10);
            if (c == 12 && hold) chk("hold_pat_cnt_flush", pat_cnt, 2);
            tick();
        end
        chk("done_at_14", done, 1);
        chk("done_busy", busy, 1);
        tick();
        start = 1'b0;
        chk("done_once", done_seen, 1);
        chk("back_idle", busy, 0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        pat_valid = 1'b0;
        pat_si = '0;
        pat_exp = '0;
        pat_mask = '0;
        pat_last = 1'b0;
        for (int i = 0; i < 4; i++) chain[i] = 4'h0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_outs", {done, fail, err_underrun, pat_ready, chain_en, chain_in}, 0);
        chk("rst_cnts", {fail_cnt, pat_cnt}, 0);
        reset = 1'b1;
        tick();

        // Clean two-pattern session.
        session(4'b0000, 4'hF, 1'b0, 0, 0, 1'b0);
        chk("clean_pat_cnt", pat_cnt, 2);
        chk("clean_fail", fail, 0);
        chk("clean_fail_cnt", fail_cnt, 0);
        chk("clean_underrun", err_underrun, 0);

        // Flush beat 1 expects bit 0 flipped, compared.
        session(4'b0010, 4'hF, 1'b0, 0, 0, 1'b0);
        chk("flip_fail", fail, 1);
        chk("flip_fail_cnt", fail_cnt, 1);
        tick();
        chk("flip_hold", {fail, fail_cnt}, 17'h1_0001);

        // Same flip but bit 0 is masked out.
        session(4'b0010, 4'hE, 1'b0, 0, 0, 1'b0);
        chk("masked_fail", fail, 0);
        chk("masked_fail_cnt", fail_cnt, 0);

        // Stream drops on the 3rd beat of the first load.
        session(4'b0000, 4'hF, 1'b0, 3, 0, 1'b0);
        chk("underrun_sticky", err_underrun, 1);

        // Reset in the middle of the flush, then a clean session.
        session(4'b0000, 4'hF, 1'b0, 0, 12, 1'b0);
        session(4'b0000, 4'hF, 1'b0, 0, 0, 1'b0);
        chk("post_rst_pat_cnt", pat_cnt, 2);
        chk("post_rst_flags", {fail, err_underrun, fail_cnt}, 0);

        // start held throughout and a stray pat_last on load 0 beat 1.
        session(4'b0000, 4'hF, 1'b1, 0, 0, 1'b0);
        chk("hold_pat_cnt", pat_cnt, 2);
        chk("hold_fail_cnt", fail_cnt, 0);
        tick();
        chk("hold_no_restart", busy, 0);

        // Saturation: preload 0xFFFE, then three mismatching flush beats.
        session(4'b0111, 4'hF, 1'b0, 0, 0, 1'b1);
        chk("sat_fail_cnt", fail_cnt, 16'hFFFF);
        chk("sat_fail", fail, 1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/scan_pattern_ctrl.md
SCAN_PATTERN_CTRL -- requirements
Module: scan_pattern_ctrl

Interface
REQ-001 Parameter N, default 4, scan chain count (width of chain_in/chain_out).
REQ-002 Parameter L, default 4, chain length in shift cycles per pattern (L >= 2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 start  input  1  begin a test session; sampled in IDLE only.
REQ-006 pat_valid  input  1  beat available on pattern stream.
REQ-007 pat_ready  output  1  beat accepted when pat_valid && pat_ready.
REQ-008 pat_si  input  N  scan-in data for this beat.
REQ-009 pat_exp  input  N  expected chain_out for this beat.
REQ-010 pat_mask  input  N  1 = compare bit, 0 = don't care.
REQ-011 pat_last  input  1  beat is final beat of final pattern load.
REQ-012 chain_en  output  1  scan enable to chain (1 = shift, 0 = capture).
REQ-013 chain_in  output  N  serial inputs to chain.
REQ-014 chain_out  input  N  serial outputs from chain.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 done  output  1  one-cycle pulse on session end.
REQ-017 fail  output  1  sticky mismatch flag, cleared on accepted start.
REQ-018 err_underrun  output  1  sticky stream-underrun flag, cleared on accepted start.
REQ-019 fail_cnt  output  16  mismatching beats, saturates at 16'hFFFF.
REQ-020 pat_cnt  output  16  patterns captured this session, saturating.

Function
REQ-021 States IDLE, SHIFT, CAPTURE, FLUSH, DONE.
REQ-022 IDLE: pat_ready=0, chain_en=0, chain_in=0; start=1 -> SHIFT, shift counter=0, fail/err_underrun/fail_cnt/pat_cnt cleared.
REQ-023 SHIFT and FLUSH: pat_ready=1; chain_en=pat_valid; chain_in=pat_si in SHIFT, 0 in FLUSH.
REQ-024 Each accepted beat compares chain_out present in that cycle (before the shifting edge): mismatch = |((chain_out ^ pat_exp) & pat_mask).
REQ-025 Mismatch registers on the accepting edge: fail=1, fail_cnt+1 (saturating); visible next cycle.
REQ-026 Shift counter increments per accepted beat, wraps to 0 after L-1.
REQ-027 SHIFT, beat with counter=L-1 -> CAPTURE; pat_last on that beat sets a last flag; pat_last on any other beat is ignored.
REQ-028 CAPTURE lasts exactly 1 cycle: chain_en=0, pat_ready=0, pat_cnt+1; next state FLUSH if last flag set else SHIFT.
REQ-029 FLUSH consumes exactly L beats (compare active, pat_si ignored), then -> DONE.
REQ-030 SHIFT or FLUSH with pat_valid=0 -> DONE with err_underrun=1; no compare, no counter update that cycle.
REQ-031 DONE lasts 1 cycle, done=1, -> IDLE; fail, err_underrun, fail_cnt, pat_cnt hold until next accepted start.
REQ-032 start outside IDLE ignored.
REQ-033 Bench/stream supplies pat_mask=0 for the first pattern's L beats (no prior response); block does not enforce this.
REQ-034 chain_en, chain_in, pat_ready are combinational from state and pat_valid only; no path from chain_out to outputs in same cycle.

Reset
REQ-035 reset=0 asynchronously forces IDLE; all outputs 0, all counters and flags 0, including mid-SHIFT/CAPTURE/FLUSH.
REQ-036 First start honoured on first rising edge after reset deasserts.

Structure
REQ-037 Shared package wrapsim_pkg holds the state enum, default N and L, and count width constant (16).
REQ-038 One sub-module scan_compare: masked compare plus saturating fail counter and sticky fail flag.

Verification (N=4, L=4)
REQ-039 2 patterns, all beats valid, chain modelled as N 4-deep shift registers, exp correct -> pat_cnt=2, fail=0, fail_cnt=0, done pulse once, 14 cycles start-to-done.
REQ-040 Same, one FLUSH beat exp bit 0 flipped, mask=4'hF -> fail=1, fail_cnt=1; same bit with mask=4'hE -> fail=0.
REQ-041 pat_valid dropped on 3rd SHIFT beat of pattern 1 -> chain_en=0 that cycle, DONE next, err_underrun=1, pat_cnt=0.
REQ-042 reset pulled low mid-FLUSH -> outputs 0 immediately (async); next start runs clean session.
REQ-043 start held high during SHIFT and DONE -> no restart, counters unaffected; pat_last on beat 1 ignored.
REQ-044 fail_cnt preloaded via forced 16'hFFFE plus 3 mismatches -> saturates at 16'hFFFF.
